// File: rtl/count_sched.sv
// Round-robin scheduler sharing one dual-channel event counter among NREQ requesters.
// Each grant drives Slt/En for exactly the requested number of enabled cycles.
module count_sched #(
    parameter int NREQ = 4,
    parameter int LW   = 4,
    parameter int IDW  = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ-1:0]    ReqSel,
    input  logic [NREQ*LW-1:0] ReqLen,
    input  logic               Hold,
    output logic [NREQ-1:0]    Gnt,
    output logic [IDW-1:0]     GntId,
    output logic               Slt,
    output logic               En,
    output logic [NREQ-1:0]    Done,
    output logic               Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic            slt_q, slt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [LW:0]     remaining_q, remaining_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

    logic            found;
    logic [IDW-1:0]  win;
    logic [LW-1:0]   win_len;

    // Search starts just after the last winner so it drops to lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && Req[(int'(rr_ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = IDW'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
        win_len = ReqLen[int'(win)*LW +: LW];
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        slt_d       = slt_q;
        done_d      = '0;
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = RUN;
                    gnt_d       = NREQ'(1) << win;
                    gnt_id_d    = win;
                    slt_d       = ReqSel[win];
                    // A zero length field encodes a full 2^LW burst.
                    remaining_d = (win_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, win_len};
                    rr_ptr_d    = win;
                end
            end
            RUN: begin
                if (!Hold) begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == (LW+1)'(1)) begin
                        state_d = DONE;
                        done_d  = gnt_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            slt_q       <= 1'b0;
            done_q      <= '0;
            remaining_q <= '0;
            rr_ptr_q    <= IDW'(NREQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            slt_q       <= slt_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign Gnt   = gnt_q;
    assign GntId = gnt_id_q;
    assign Slt   = slt_q;
    assign Done  = done_q;
    assign Busy  = (state_q != IDLE);
    assign En    = (state_q == RUN) && !Hold;

endmodule

// File: tb/tb_count_sched.sv
// Directed self-checking bench for count_sched: arbitration order, burst length,
// stall, zero-length encoding, reset mid-burst and input changes during a burst.
module tb_count_sched;
    localparam int NREQ = 4;
    localparam int LW   = 4;
    localparam int IDW  = 2;

    logic               Clk = 1'b0;
    logic               Reset;
    logic [NREQ-1:0]    Req;
    logic [NREQ-1:0]    ReqSel;
    logic [NREQ*LW-1:0] ReqLen;
    logic               Hold;
    logic [NREQ-1:0]    Gnt;
    logic [IDW-1:0]     GntId;
    logic               Slt;
    logic               En;
    logic [NREQ-1:0]    Done;
    logic               Busy;

    int checks = 0;
    int passes = 0;

    count_sched #(.NREQ(NREQ), .LW(LW), .IDW(IDW)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .ReqSel(ReqSel), .ReqLen(ReqLen),
        .Hold(Hold), .Gnt(Gnt), .GntId(GntId), .Slt(Slt), .En(En), .Done(Done),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b1; Req = '0; ReqSel = '0; ReqLen = '0; Hold = 1'b0;
        tick; tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Req = 4'hF; ReqSel = 4'hF; ReqLen = 16'h1111; Hold = 1'b0;
        tick; tick;
        Reset = 1'b0; Req = '0;
        #1;
        if (Gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", Gnt); else passes++;
        checks++;
        if (GntId !== 2'd0) $display("FAIL reset_gntid: got %0d want 0", GntId); else passes++;
        checks++;
        if (Slt !== 1'b0) $display("FAIL reset_slt: got %b want 0", Slt); else passes++;
        checks++;
        if (Done !== 4'b0000) $display("FAIL reset_done: got %b want 0000", Done); else passes++;
        checks++;
        if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else passes++;
        checks++;
        if (En !== 1'b0) $display("FAIL reset_en: got %b want 0", En); else passes++;
        checks++;
    endtask

    task automatic test_single;
        logic [4:0] en_exp, done_exp, busy_exp;
        en_exp = 5'b00111; done_exp = 5'b01000; busy_exp = 5'b01111;
        do_reset;
        Req = 4'b0001; ReqSel = 4'b0001; ReqLen = 16'h0003;
        for (int c = 1; c <= 5; c++) begin
            tick;
            if (c == 1) begin
                if (Gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", Gnt); else passes++;
                checks++;
                if (Slt !== 1'b1) $display("FAIL single_slt: got %b want 1", Slt); else passes++;
                checks++;
            end
            if (En !== en_exp[c-1]) $display("FAIL single_en c%0d: got %b want %b", c, En, en_exp[c-1]); else passes++;
            checks++;
            if (Done !== (done_exp[c-1] ? 4'b0001 : 4'b0000))
                $display("FAIL single_done c%0d: got %b want %b", c, Done, done_exp[c-1] ? 4'b0001 : 4'b0000);
            else passes++;
            checks++;
            if (Busy !== busy_exp[c-1]) $display("FAIL single_busy c%0d: got %b want %b", c, Busy, busy_exp[c-1]); else passes++;
            checks++;
            if (c == 4) Req = '0;
        end
    endtask

    task automatic test_contention;
        logic [NREQ-1:0] g;
        logic [IDW-1:0]  id;
        do_reset;
        Req = 4'hF; ReqSel = 4'h0; ReqLen = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            id = IDW'(k % NREQ);
            g  = NREQ'(1) << id;
            tick;
            if (Gnt !== g || GntId !== id)
                $display("FAIL contention_grant k%0d: got %b/%0d want %b/%0d", k, Gnt, GntId, g, id);
            else passes++;
            checks++;
            if (En !== 1'b1) $display("FAIL contention_en k%0d: got %b want 1", k, En); else passes++;
            checks++;
            tick;
            if (Done !== g || En !== 1'b0)
                $display("FAIL contention_done k%0d: got %b en %b want %b en 0", k, Done, En, g);
            else passes++;
            checks++;
            tick;
            if (Busy !== 1'b0 || Gnt !== 4'b0000)
                $display("FAIL contention_idle k%0d: got busy %b gnt %b want 0 0000", k, Busy, Gnt);
            else passes++;
            checks++;
            if (k == 4) Req = '0;
        end
    endtask

    task automatic test_fairness;
        logic [NREQ-1:0] g;
        logic [IDW-1:0]  id;
        do_reset;
        Req = 4'b0101; ReqSel = 4'b0000; ReqLen = 16'h0202;
        for (int k = 0; k < 4; k++) begin
            id = IDW'((k % 2) * 2);
            g  = NREQ'(1) << id;
            tick;
            if (Gnt !== g || GntId !== id)
                $display("FAIL fair_grant k%0d: got %b/%0d want %b/%0d", k, Gnt, GntId, g, id);
            else passes++;
            checks++;
            tick;
            if (En !== 1'b1) $display("FAIL fair_en k%0d: got %b want 1", k, En); else passes++;
            checks++;
            tick;
            if (Done !== g) $display("FAIL fair_done k%0d: got %b want %b", k, Done, g); else passes++;
            checks++;
            tick;
            if (k == 3) Req = '0;
        end
    endtask

    task automatic test_hold;
        logic [8:0] en_exp;
        int en_cnt, done_c;
        en_exp = 9'b001100011; en_cnt = 0; done_c = 0;
        do_reset;
        Req = 4'b0001; ReqSel = 4'b0000; ReqLen = 16'h0004;
        for (int c = 1; c <= 9; c++) begin
            tick;
            Hold = (c >= 3 && c <= 5);
            #1;
            if (En !== en_exp[c-1]) $display("FAIL hold_en c%0d: got %b want %b", c, En, en_exp[c-1]); else passes++;
            checks++;
            if (En === 1'b1) en_cnt++;
            if (Done === 4'b0001 && done_c == 0) begin
                done_c = c;
                Req = '0;
            end
        end
        Hold = 1'b0;
        if (en_cnt != 4) $display("FAIL hold_en_count: got %0d want 4", en_cnt); else passes++;
        checks++;
        if (done_c != 8) $display("FAIL hold_done_cycle: got %0d want 8", done_c); else passes++;
        checks++;
    endtask

    task automatic test_len_zero;
        int en_cnt, done_c, slt_bad;
        logic [NREQ-1:0] done_val;
        en_cnt = 0; done_c = 0; slt_bad = 0; done_val = '0;
        do_reset;
        Req = 4'b0010; ReqSel = 4'b0000; ReqLen = 16'h0000;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (c == 1) begin
                if (Gnt !== 4'b0010 || GntId !== 2'd1)
                    $display("FAIL len0_grant: got %b/%0d want 0010/1", Gnt, GntId);
                else passes++;
                checks++;
            end
            if (En === 1'b1) en_cnt++;
            if (Busy === 1'b1 && Slt !== 1'b0) slt_bad++;
            if (Done !== 4'b0000 && done_c == 0) begin
                done_c = c;
                done_val = Done;
                Req = '0;
            end
        end
        if (en_cnt != 16) $display("FAIL len0_en_count: got %0d want 16", en_cnt); else passes++;
        checks++;
        if (done_c != 17 || done_val !== 4'b0010)
            $display("FAIL len0_done: got cycle %0d val %b want cycle 17 val 0010", done_c, done_val);
        else passes++;
        checks++;
        if (slt_bad != 0) $display("FAIL len0_slt: got %0d bad cycles want 0", slt_bad); else passes++;
        checks++;
        if (Busy !== 1'b0) $display("FAIL len0_idle: got busy %b want 0", Busy); else passes++;
        checks++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        Req = 4'b0100; ReqSel = 4'b0100; ReqLen = 16'h0500;
        tick;
        tick;
        if (En !== 1'b1 || Gnt !== 4'b0100)
            $display("FAIL rstmid_run: got en %b gnt %b want 1 0100", En, Gnt);
        else passes++;
        checks++;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        Req = 4'b1100; ReqLen = 16'h1100; ReqSel = 4'b0000;
        #1;
        if (En !== 1'b0 || Gnt !== 4'b0000 || Busy !== 1'b0 || Done !== 4'b0000)
            $display("FAIL rstmid_clear: got en %b gnt %b busy %b done %b want 0 0000 0 0000", En, Gnt, Busy, Done);
        else passes++;
        checks++;
        tick;
        if (Gnt !== 4'b0100 || GntId !== 2'd2 || Done !== 4'b0000)
            $display("FAIL rstmid_rearb: got %b/%0d done %b want 0100/2 done 0000", Gnt, GntId, Done);
        else passes++;
        checks++;
        tick;
        if (Done !== 4'b0100) $display("FAIL rstmid_done: got %b want 0100", Done); else passes++;
        checks++;
        Req = '0;
        tick;
    endtask

    task automatic test_len_change;
        int en_cnt, slt_bad, done_c;
        slt_bad = 0; done_c = 0;
        do_reset;
        Req = 4'b0001; ReqSel = 4'b0001; ReqLen = 16'h0003;
        tick;
        en_cnt = (En === 1'b1) ? 1 : 0;
        ReqLen = 16'h0007; ReqSel = 4'b0000; Req = '0;
        for (int c = 2; c <= 9; c++) begin
            tick;
            if (En === 1'b1) en_cnt++;
            if (Busy === 1'b1 && Slt !== 1'b1) slt_bad++;
            if (Done === 4'b0001 && done_c == 0) done_c = c;
        end
        if (en_cnt != 3) $display("FAIL lenchg_en_count: got %0d want 3", en_cnt); else passes++;
        checks++;
        if (done_c != 4) $display("FAIL lenchg_done_cycle: got %0d want 4", done_c); else passes++;
        checks++;
        if (slt_bad != 0) $display("FAIL lenchg_slt: got %0d bad cycles want 0", slt_bad); else passes++;
        checks++;
    endtask

    initial begin
        Reset = 1'b1; Req = '0; ReqSel = '0; ReqLen = '0; Hold = 1'b0;
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_hold;
        test_len_zero;
        test_reset_mid;
        test_len_change;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
